// File: rtl/bp_pkg.sv
// Shared definitions for the BHT/BTB branch predictor.
// Contents: direction-counter encodings and PC index/tag extraction helpers.
// The helpers work on a 64-bit word and take the run-time widths as
// arguments, so any XLEN/ENTRIES/CTR_W up to 64 bits can use them. The
// caller narrows each result with a width cast.
package bp_pkg;

  localparam int unsigned BP_WORD_W = 64;

  typedef logic [BP_WORD_W-1:0] bp_word_t;

  // Table entry for the default configuration (XLEN=32, ENTRIES=16, CTR_W=2).
  // The predictor builds its own entry type from its actual parameters.
  typedef struct packed {
    logic        valid;
    logic [25:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } bp_entry_t;

  // Weakly-taken encoding: MSB set, all lower bits clear.
  function automatic bp_word_t ctr_weak_t(input int unsigned ctr_w);
    return bp_word_t'(1) << (ctr_w - 1);
  endfunction

  // Weakly-not-taken encoding: MSB clear, all lower bits set.
  function automatic bp_word_t ctr_weak_nt(input int unsigned ctr_w);
    return (bp_word_t'(1) << (ctr_w - 1)) - bp_word_t'(1);
  endfunction

  // Table index is pc[idx_w+1:2]; pc[1:0] is ignored.
  function automatic bp_word_t bp_index(input bp_word_t pc, input int unsigned idx_w);
    return (pc >> 2) & ((bp_word_t'(1) << idx_w) - bp_word_t'(1));
  endfunction

  // Tag is every PC bit above the index.
  function automatic bp_word_t bp_tag(input bp_word_t pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bht_btb_predictor_sat_counter.sv
// sat_counter: combinational saturating up/down step.
// Ports: inc/dec request a step (both or neither hold the value), value is the
// current count, next_value is the stepped count clamped to [0, all-ones].
module sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic [W-1:0] next_value
);

  always_comb begin
    next_value = value;
    if (inc && !dec && (value != {W{1'b1}})) begin
      next_value = value + W'(1);
    end else if (dec && !inc && (value != '0)) begin
      next_value = value - W'(1);
    end
  end

endmodule

// File: rtl/bht_btb_predictor.sv
// bht_btb_predictor: direct-mapped BTB with per-entry saturating direction
// counters, plus saturating branch/mispredict statistics.
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync invalidate of all entries)
//   pc_i -> pred_taken_o / pred_target_o : zero-latency IF-stage lookup
//   upd_* : one resolved conditional branch per cycle from ID, trains table
//   branch_cnt_o / mispred_cnt_o : saturating statistics
module bht_btb_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [XLEN-1:0]  upd_pred_target_i,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(ctr_weak_t(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  entry_t table_q [ENTRIES];
  entry_t table_d [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, mispred;
  logic [CTR_W-1:0] up_ctr_next;

  // Lookup path: reads only the registered table, so X on pc_i stays here.
  always_comb begin
    lk_idx        = IDX_W'(bp_index(bp_word_t'(pc_i), IDX_W));
    lk_tag        = TAG_W'(bp_tag(bp_word_t'(pc_i), IDX_W));
    lk_hit        = table_q[lk_idx].valid && (table_q[lk_idx].tag == lk_tag);
    pred_taken_o  = lk_hit && table_q[lk_idx].ctr[CTR_W-1];
    pred_target_o = pred_taken_o ? table_q[lk_idx].target : pc_i + XLEN'(4);
  end

  always_comb begin
    up_idx  = IDX_W'(bp_index(bp_word_t'(upd_pc_i), IDX_W));
    up_tag  = TAG_W'(bp_tag(bp_word_t'(upd_pc_i), IDX_W));
    up_hit  = table_q[up_idx].valid && (table_q[up_idx].tag == up_tag);
    mispred = upd_valid_i &&
              ((upd_pred_taken_i != upd_taken_i) ||
               (upd_taken_i && upd_pred_taken_i && (upd_pred_target_i != upd_target_i)));
  end

  sat_counter #(.W(CTR_W)) u_dir_ctr (
    .inc        (upd_taken_i),
    .dec        (!upd_taken_i),
    .value      (table_q[up_idx].ctr),
    .next_value (up_ctr_next)
  );

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .inc        (upd_valid_i),
    .dec        (1'b0),
    .value      (branch_cnt_q),
    .next_value (branch_cnt_d)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .inc        (mispred),
    .dec        (1'b0),
    .value      (mispred_cnt_q),
    .next_value (mispred_cnt_d)
  );

  // Table next-state; clear overrides any same-cycle training.
  always_comb begin
    table_d = table_q;
    if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_d[i].valid = 1'b0;
      end
    end else if (upd_valid_i) begin
      if (up_hit) begin
        table_d[up_idx].ctr = up_ctr_next;
        if (upd_taken_i) begin
          table_d[up_idx].target = upd_target_i;
        end
      end else if (upd_taken_i) begin
        table_d[up_idx].valid  = 1'b1;
        table_d[up_idx].tag    = up_tag;
        table_d[up_idx].target = upd_target_i;
        table_d[up_idx].ctr    = CTR_WEAK_T;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      table_q       <= table_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_bht_btb_predictor.sv
// Directed self-checking bench for bht_btb_predictor (default parameters).
module tb_bht_btb_predictor;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic [31:0] pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bht_btb_predictor dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .clear_i           (clear_i),
    .pc_i              (pc_i),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .branch_cnt_o      (branch_cnt_o),
    .mispred_cnt_o     (mispred_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Lookup at pc and compare the combinational prediction.
  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_taken, input logic [31:0] exp_target);
    pc_i = pc;
    #1;
    check({tag, "_taken"}, 32'(pred_taken_o), 32'(exp_taken));
    check({tag, "_target"}, pred_target_o, exp_target);
  endtask

  task automatic stats(input string tag, input logic [31:0] exp_b, input logic [31:0] exp_m);
    check({tag, "_bcnt"}, branch_cnt_o, exp_b);
    check({tag, "_mcnt"}, mispred_cnt_o, exp_m);
  endtask

  // Present one update from a negedge, hold it across one rising edge.
  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic ptaken, input logic [31:0] ptgt);
    upd_valid_i       = 1'b1;
    upd_pc_i          = pc;
    upd_taken_i       = taken;
    upd_target_i      = tgt;
    upd_pred_taken_i  = ptaken;
    upd_pred_target_i = ptgt;
    @(negedge clk);
    upd_valid_i = 1'b0;
    clear_i     = 1'b0;
  endtask

  initial begin
    rst_i             = 1'b1;
    clear_i           = 1'b0;
    pc_i              = 32'h0;
    upd_valid_i       = 1'b0;
    upd_pc_i          = 32'h0;
    upd_taken_i       = 1'b0;
    upd_target_i      = 32'h0;
    upd_pred_taken_i  = 1'b0;
    upd_pred_target_i = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    // Reset state
    look("rst_40", 32'h40, 1'b0, 32'h44);
    stats("rst", 0, 0);

    // First taken update allocates weakly-taken entry
    upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h44);
    look("alloc_40", 32'h40, 1'b1, 32'h20);
    stats("alloc", 1, 1);

    // Decrement to floor
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h20);
    look("nt1_40", 32'h40, 1'b0, 32'h44);
    stats("nt1", 2, 2);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    stats("nt3", 4, 2);
    // From 00, two increments reach 10 (a wrap would leave it at 01)
    upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h44);
    look("floor_t1", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h44);
    look("floor_t2", 32'h40, 1'b1, 32'h20);
    stats("floor", 6, 4);

    // Aliasing at index 0
    look("alias_80_miss", 32'h80, 1'b0, 32'h84);
    upd(32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
    look("alias_80_hit", 32'h80, 1'b1, 32'h100);
    look("alias_40_miss", 32'h40, 1'b0, 32'h44);
    stats("alias", 7, 5);

    // Saturation at top; last taken update also retargets
    upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h20, 1'b1, 32'h20);
    upd(32'h40, 1'b1, 32'h20, 1'b1, 32'h20);
    upd(32'h40, 1'b1, 32'h20, 1'b1, 32'h20);
    stats("sat_correct", 11, 6);
    upd(32'h40, 1'b1, 32'h28, 1'b1, 32'h20);
    look("retarget_40", 32'h40, 1'b1, 32'h28);
    stats("tgt_mispred", 12, 7);
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h28);
    look("sat_nt1", 32'h40, 1'b1, 32'h28);
    // Same-cycle lookup sees the pre-update counter (10), not the new 01
    pc_i              = 32'h40;
    upd_valid_i       = 1'b1;
    upd_pc_i          = 32'h40;
    upd_taken_i       = 1'b0;
    upd_target_i      = 32'h0;
    upd_pred_taken_i  = 1'b1;
    upd_pred_target_i = 32'h28;
    look("nobypass", 32'h40, 1'b1, 32'h28);
    @(negedge clk);
    upd_valid_i = 1'b0;
    look("sat_nt2", 32'h40, 1'b0, 32'h44);
    stats("sat", 14, 9);

    // Clear together with a taken update: table cleared, stats still count
    clear_i = 1'b1;
    upd(32'hC0, 1'b1, 32'h200, 1'b0, 32'hC4);
    look("clr_80", 32'h80, 1'b0, 32'h84);
    look("clr_c0", 32'hC0, 1'b0, 32'hC4);
    look("clr_40", 32'h40, 1'b0, 32'h44);
    stats("clr", 15, 10);

    // Miss + not-taken leaves table alone; PC+4 wraps
    upd(32'h80, 1'b0, 32'h0, 1'b0, 32'h84);
    look("miss_nt_80", 32'h80, 1'b0, 32'h84);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    stats("miss_nt", 16, 10);

    // Asynchronous reset between edges
    upd(32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
    look("pre_rst_80", 32'h80, 1'b1, 32'h100);
    stats("pre_rst", 17, 11);
    #2;
    rst_i = 1'b1;
    look("async_rst_80", 32'h80, 1'b0, 32'h84);
    stats("async_rst", 0, 0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    look("post_rst_80", 32'h80, 1'b0, 32'h84);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
